// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Two-master arbiter for the shared program/data RAM. Master 0 is
//            the CPU, master 1 the program loader / debug port. The grant is
//            registered and round-robin, bus hold is bounded while the other
//            master waits, and read data is routed back to the issuing master.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic [1:0]    m0_cmd,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic [1:0]    m1_cmd,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] rdata,
  output logic [1:0]    ram_cmd,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  // Command encoding; 2'b11 is never forwarded to the RAM.
  localparam logic [1:0] c_MNONE  = 2'b00;
  localparam logic [1:0] c_MREAD  = 2'b01;
  localparam logic [1:0] c_MWRITE = 2'b10;

  // Ownership states.
  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_OWN0 = 2'd1;
  localparam logic [1:0] c_ST_OWN1 = 2'd2;

  // Hold counter only needs to reach MAX_HOLD-1 before a handoff clears it.
  localparam int             HW          = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]  c_HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_prio;
  logic [HW-1:0] r_hold;
  logic          r_m0_rvalid;
  logic          r_m1_rvalid;

  logic          w_own0;
  logic          w_own1;
  logic          w_m0_cmd_ok;
  logic          w_m1_cmd_ok;
  logic [1:0]    w_ram_cmd;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_wdata;

  assign w_own0      = (r_state == c_ST_OWN0);
  assign w_own1      = (r_state == c_ST_OWN1);
  assign w_m0_cmd_ok = (m0_cmd == c_MREAD) || (m0_cmd == c_MWRITE);
  assign w_m1_cmd_ok = (m1_cmd == c_MREAD) || (m1_cmd == c_MWRITE);

  // Route the owner's request to the RAM; a released (req=0) cycle issues nothing.
  always_comb begin
    w_ram_cmd   = c_MNONE;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    if (w_own0) begin
      w_ram_addr  = m0_addr;
      w_ram_wdata = m0_wdata;
      if (m0_req && w_m0_cmd_ok) w_ram_cmd = m0_cmd;
    end else if (w_own1) begin
      w_ram_addr  = m1_addr;
      w_ram_wdata = m1_wdata;
      if (m1_req && w_m1_cmd_ok) w_ram_cmd = m1_cmd;
    end
    if (reset) w_ram_cmd = c_MNONE;
  end

  // Next owner: round-robin from idle, direct handoff on release or hold expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (m0_req && m1_req) w_state_nxt = r_prio ? c_ST_OWN1 : c_ST_OWN0;
        else if (m0_req)      w_state_nxt = c_ST_OWN0;
        else if (m1_req)      w_state_nxt = c_ST_OWN1;
      end
      c_ST_OWN0: begin
        if (!m0_req)                               w_state_nxt = m1_req ? c_ST_OWN1 : c_ST_IDLE;
        else if (m1_req && (r_hold == c_HOLD_LAST)) w_state_nxt = c_ST_OWN1;
      end
      c_ST_OWN1: begin
        if (!m1_req)                               w_state_nxt = m0_req ? c_ST_OWN0 : c_ST_IDLE;
        else if (m0_req && (r_hold == c_HOLD_LAST)) w_state_nxt = c_ST_OWN0;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Ownership, fairness, hold timer and read-return tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_ST_IDLE;
      r_prio      <= 1'b0;
      r_hold      <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_hold <= '0;
      else if ((w_own0 && m1_req) || (w_own1 && m0_req))
        r_hold <= r_hold + 1'b1;
      // Whoever just gained the bus yields priority to the other master.
      if ((w_state_nxt == c_ST_OWN0) && !w_own0)
        r_prio <= 1'b1;
      else if ((w_state_nxt == c_ST_OWN1) && !w_own1)
        r_prio <= 1'b0;
      r_m0_rvalid <= w_own0 && (w_ram_cmd == c_MREAD);
      r_m1_rvalid <= w_own1 && (w_ram_cmd == c_MREAD);
    end
  end

  assign m0_gnt    = w_own0;
  assign m1_gnt    = w_own1;
  // A reset arriving right after a read cancels its return.
  assign m0_rvalid = r_m0_rvalid && !reset;
  assign m1_rvalid = r_m1_rvalid && !reset;
  assign rdata     = ram_rdata;
  assign ram_cmd   = w_ram_cmd;
  assign ram_addr  = w_ram_addr;
  assign ram_wdata = w_ram_wdata;

endmodule
`default_nettype wire
